rom_port_arbiter: RTL

- Shares the single combinational program-memory read port (16-bit address in, 16-bit word out) between two requesters.
- Requester F is instruction fetch; requester L is the data port for constant and table loads from program memory.
- Grants at most one access per cycle, registers the returned word, and pulses a per-port valid one cycle later.
- Sits between the core's fetch/load units and the program memory instance.

---
 rtl/rom_port_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/rom_port_arbiter.sv
// Two-requester arbiter for the shared combinational program-memory read port.
// Fetch (F) and load (L) ports each get a registered word and a one-cycle valid pulse.
module rom_port_arbiter #(
    parameter int          ARB_MODE  = 0,
    parameter int          MAX_WAIT  = 4,
    parameter logic [15:0] IDLE_ADDR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [15:0] f_addr,
    input  logic        f_flush,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [15:0] f_rdata,
    input  logic        l_req,
    input  logic [15:0] l_addr,
    output logic        l_gnt,
    output logic        l_rvalid,
    output logic [15:0] l_rdata,
    output logic [15:0] rom_address,
    input  logic [15:0] rom_data,
    output logic        busy
);

    localparam logic       WIN_F      = 1'b0;
    localparam logic       WIN_L      = 1'b1;
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic        last_winner_q, last_winner_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        f_rvalid_q, f_rvalid_d;
    logic        l_rvalid_q, l_rvalid_d;
    logic [15:0] f_rdata_q, f_rdata_d;
    logic [15:0] l_rdata_q, l_rdata_d;
    logic        f_gnt_c, l_gnt_c;

    // Grants are suppressed while reset is held so no access can start mid-reset.
    always_comb begin
        f_gnt_c = 1'b0;
        l_gnt_c = 1'b0;
        if (!rst) begin
            if (ARB_MODE == 0) begin
                if (f_req && l_req) begin
                    if (last_winner_q == WIN_L) f_gnt_c = 1'b1;
                    else                        l_gnt_c = 1'b1;
                end else begin
                    f_gnt_c = f_req;
                    l_gnt_c = l_req;
                end
            end else begin
                if (l_req && (wait_cnt_q == MAX_WAIT_C)) l_gnt_c = 1'b1;
                else if (f_req)                          f_gnt_c = 1'b1;
                else                                     l_gnt_c = l_req;
            end
        end
    end

    always_comb begin
        last_winner_d = last_winner_q;
        if (f_gnt_c)      last_winner_d = WIN_F;
        else if (l_gnt_c) last_winner_d = WIN_L;

        // Starvation counter only matters in fixed-priority mode.
        wait_cnt_d = 4'd0;
        if ((ARB_MODE != 0) && l_req && !l_gnt_c) begin
            if (wait_cnt_q < MAX_WAIT_C) wait_cnt_d = wait_cnt_q + 4'd1;
            else                         wait_cnt_d = wait_cnt_q;
        end

        f_rvalid_d = f_gnt_c;
        l_rvalid_d = l_gnt_c;
        f_rdata_d  = f_gnt_c ? rom_data : f_rdata_q;
        l_rdata_d  = l_gnt_c ? rom_data : l_rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_winner_q <= WIN_L;
            wait_cnt_q    <= 4'd0;
            f_rvalid_q    <= 1'b0;
            l_rvalid_q    <= 1'b0;
            f_rdata_q     <= 16'h0000;
            l_rdata_q     <= 16'h0000;
        end else begin
            last_winner_q <= last_winner_d;
            wait_cnt_q    <= wait_cnt_d;
            f_rvalid_q    <= f_rvalid_d;
            l_rvalid_q    <= l_rvalid_d;
            f_rdata_q     <= f_rdata_d;
            l_rdata_q     <= l_rdata_d;
        end
    end

    // A flush in the response cycle hides the fetch pulse; the data register is untouched.
    assign f_rvalid    = f_rvalid_q & ~f_flush;
    assign l_rvalid    = l_rvalid_q;
    assign f_rdata     = f_rdata_q;
    assign l_rdata     = l_rdata_q;
    assign f_gnt       = f_gnt_c;
    assign l_gnt       = l_gnt_c;
    assign busy        = f_gnt_c | l_gnt_c;
    assign rom_address = f_gnt_c ? f_addr : (l_gnt_c ? l_addr : IDLE_ADDR);

endmodule
